// File: rtl/ram_1port_bist.sv
// Write-then-verify engine around an inferred single-port synchronous RAM.
// Fills every word with a mode-selected pattern, reads it back and reports mismatches.
module ram_1port_bist #(
  parameter int DW    = 8,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic          inj_en,
  input  logic [AW-1:0] inj_addr,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic          first_err_vld,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Address is zero-extended (or truncated) to DW before the DW-bit modulo arithmetic.
  function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [DW-1:0] s,
                                            input logic [AW-1:0] a);
    logic [DW-1:0] a_ext;
    logic [DW-1:0] one;
    a_ext = DW'(a);
    one   = {{(DW-1){1'b0}}, 1'b1};
    case (m)
      2'd0:    pattern = a_ext + s;
      2'd1:    pattern = ~(a_ext + s);
      2'd2:    pattern = one << (32'(a) % DW);
      2'd3:    pattern = s;
      default: pattern = s;
    endcase
  endfunction

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] seed_q, seed_d;
  logic          inj_en_q, inj_en_d;
  logic [AW-1:0] inj_addr_q, inj_addr_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [DW-1:0] exp_q, exp_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          first_vld_q, first_vld_d;
  logic [AW-1:0] first_addr_q, first_addr_d;
  logic          wren, rden, mismatch;
  logic [DW-1:0] wdata;

  // Next-state, RAM control and result bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    inj_en_d     = inj_en_q;
    inj_addr_d   = inj_addr_q;
    cmp_vld_d    = 1'b0;
    cmp_addr_d   = cmp_addr_q;
    exp_d        = exp_q;
    err_cnt_d    = err_cnt_q;
    first_vld_d  = first_vld_q;
    first_addr_d = first_addr_q;
    pass_d       = pass_q;
    wren         = 1'b0;
    rden         = 1'b0;
    wdata        = pattern(mode_q, seed_q, cnt_q);
    if (inj_en_q && (cnt_q == inj_addr_q)) begin
      wdata[0] = ~wdata[0];
    end else begin
      wdata[0] = wdata[0];
    end
    mismatch = cmp_vld_q && (rdata_q != exp_q);
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (!first_vld_q) begin
        first_vld_d  = 1'b1;
        first_addr_d = cmp_addr_q;
      end else begin
        first_vld_d  = first_vld_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WRITE;
          cnt_d       = {AW{1'b0}};
          mode_d      = mode;
          seed_d      = seed;
          inj_en_d    = inj_en;
          inj_addr_d  = inj_addr;
          err_cnt_d   = 16'd0;
          first_vld_d = 1'b0;
          pass_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        wren = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_READ;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_READ: begin
        rden       = 1'b1;
        cmp_vld_d  = 1'b1;
        cmp_addr_d = cnt_q;
        exp_d      = pattern(mode_q, seed_q, cnt_q);
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      // The last read word is compared here, so pass must see this cycle's count.
      S_DRAIN: begin
        state_d = S_DONE;
        pass_d  = (err_cnt_d == 16'd0);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {AW{1'b0}};
      mode_q       <= 2'd0;
      seed_q       <= {DW{1'b0}};
      inj_en_q     <= 1'b0;
      inj_addr_q   <= {AW{1'b0}};
      cmp_vld_q    <= 1'b0;
      cmp_addr_q   <= {AW{1'b0}};
      exp_q        <= {DW{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= 16'd0;
      first_vld_q  <= 1'b0;
      first_addr_q <= {AW{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      inj_en_q     <= inj_en_d;
      inj_addr_q   <= inj_addr_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_addr_q   <= cmp_addr_d;
      exp_q        <= exp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      first_vld_q  <= first_vld_d;
      first_addr_q <= first_addr_d;
    end
  end

  // RAM array and its registered read port; contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (wren) begin
      mem_q[cnt_q] <= wdata;
    end
    if (rden) begin
      rdata_q <= mem_q[cnt_q];
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_vld  = first_vld_q;
  assign first_err_addr = first_addr_q;

endmodule
